// File: rtl/alu_pkg.sv
// Shared types for the ALU: opcode map, compare codes and divider state.
// Optional build macro used by this slice: ALU_OVF_EN (adds the ovf output).
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_NOR   = 4'b0100,
        OP_SLL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_SLTU  = 4'b1010,
        OP_LUI   = 4'b1011,
        OP_DIVQ  = 4'b1100,
        OP_DIVR  = 4'b1101,
        OP_DIVUQ = 4'b1110,
        OP_DIVUR = 4'b1111
    } alu_op_e;

    typedef enum logic {
        DIV_BUSY = 1'b0,
        DIV_DONE = 1'b1
    } div_state_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath (master) and the ALU (slave).
// With ALU_OVF_EN defined the bundle also carries the ovf flag.
interface alu_if
    import alu_pkg::*;
#(
    parameter int W = ALU_W
);
    // a/b/ctrl are sampled continuously; out/comp for ops 0000-1011 are valid the same cycle.
    // For ops 11xx out is valid only while done is high; done holds until divrst is next low.
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctrl;
    logic [W-1:0] out;
    logic [1:0]   comp;
    logic         done;
    div_state_e   div_state;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    modport master (
        output a, b, ctrl,
`ifdef ALU_OVF_EN
        input  ovf,
`endif
        input  out, comp, done, div_state
    );

    modport slave (
        input  a, b, ctrl,
`ifdef ALU_OVF_EN
        output ovf,
`endif
        output out, comp, done, div_state
    );

endinterface

// File: rtl/alu_divider.sv
// Sequential restoring divider: loads while divrst is low, then one quotient bit per clock.
// Results and done hold until divrst is next asserted.
module alu_divider
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         divrst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_mode,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done,
    output div_state_e   state
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0] ONE = W'(1);

    div_state_e    r_state;
    div_state_e    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_div;
    logic [W-1:0]  r_dvd;
    logic          r_qneg;
    logic          r_rneg;
    logic [W-1:0]  r_q_res;
    logic [W-1:0]  r_r_res;

    logic [W-1:0]  w_abs_a;
    logic [W-1:0]  w_abs_b;
    logic [W:0]    w_rem_sh;
    logic [W:0]    w_trial;
    logic          w_fit;
    logic [W-1:0]  w_rem_nx;
    logic [W-1:0]  w_quo_nx;
    logic [W-1:0]  w_q_fin;
    logic [W-1:0]  w_r_fin;

    assign w_abs_a = (signed_mode && a[W-1]) ? (~a + ONE) : a;
    assign w_abs_b = (signed_mode && b[W-1]) ? (~b + ONE) : b;

    assign w_rem_sh = {r_rem, r_quo[W-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div};
    assign w_fit    = ~w_trial[W];
    assign w_rem_nx = w_fit ? w_trial[W-1:0] : w_rem_sh[W-1:0];
    assign w_quo_nx = {r_quo[W-2:0], w_fit};

    // Zero divisor bypasses the sign fix-up so the remainder is the original dividend.
    assign w_q_fin = (r_div == '0) ? '1    : (r_qneg ? (~w_quo_nx + ONE) : w_quo_nx);
    assign w_r_fin = (r_div == '0) ? r_dvd : (r_rneg ? (~w_rem_nx + ONE) : w_rem_nx);

    always_ff @(posedge clk) begin
        if (!divrst) begin
            r_state <= DIV_BUSY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == DIV_BUSY && r_cnt == CW'(1)) begin
            w_state_nx = DIV_DONE;
        end
    end

    always_comb begin
        done  = (r_state == DIV_DONE);
        state = r_state;
    end

    always_ff @(posedge clk) begin
        if (!divrst) begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_div   <= w_abs_b;
            r_dvd   <= a;
            r_qneg  <= signed_mode & (a[W-1] ^ b[W-1]);
            r_rneg  <= signed_mode & a[W-1];
            r_cnt   <= CW'(W);
            r_q_res <= '0;
            r_r_res <= '0;
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_q_res <= w_q_fin;
                r_r_res <= w_r_fin;
            end
        end
    end

    assign quotient  = r_q_res;
    assign remainder = r_r_res;

endmodule

// File: rtl/alu.sv
// MIPS-style ALU: same-cycle logic/shift/arith/compare ops plus a registered divider read by opcode.
// Define ALU_OVF_EN to drive the signed-overflow flag for ADD/SUB.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic  clk,
    input  logic  divrst,
    alu_if.slave  bus
);

    localparam int SHW = $clog2(W);

    logic [SHW-1:0] w_sh;
    logic [W-1:0]   w_sum;
    logic [W-1:0]   w_diff;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_res;
    logic           w_done;
    div_state_e     w_div_state;

    assign w_sh   = bus.b[SHW-1:0];
    assign w_sum  = bus.a + bus.b;
    assign w_diff = bus.a - bus.b;

    // Mode comes from ctrl[1] (0 = signed) and is only sampled while the divider loads.
    alu_divider #(.W(W)) u_div (
        .clk         (clk),
        .divrst      (divrst),
        .a           (bus.a),
        .b           (bus.b),
        .signed_mode (~bus.ctrl[1]),
        .quotient    (w_quo),
        .remainder   (w_rem),
        .done        (w_done),
        .state       (w_div_state)
    );

    always_comb begin
        w_res = '0;
        case (alu_op_e'(bus.ctrl))
            OP_AND:   w_res = bus.a & bus.b;
            OP_OR:    w_res = bus.a | bus.b;
            OP_ADD:   w_res = w_sum;
            OP_XOR:   w_res = bus.a ^ bus.b;
            OP_NOR:   w_res = ~(bus.a | bus.b);
            OP_SLL:   w_res = bus.a << w_sh;
            OP_SUB:   w_res = w_diff;
            OP_SLT:   w_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SRL:   w_res = bus.a >> w_sh;
            OP_SRA:   w_res = $unsigned($signed(bus.a) >>> w_sh);
            OP_SLTU:  w_res = {{(W-1){1'b0}}, (bus.a < bus.b)};
            OP_LUI:   w_res = {bus.b[15:0], {(W-16){1'b0}}};
            OP_DIVQ,
            OP_DIVUQ: w_res = w_quo;
            OP_DIVR,
            OP_DIVUR: w_res = w_rem;
            default:  w_res = '0;
        endcase
    end

    always_comb begin
        bus.comp = CMP_GT;
        if (bus.a == bus.b) begin
            bus.comp = CMP_EQ;
        end else if ($signed(bus.a) < $signed(bus.b)) begin
            bus.comp = CMP_LT;
        end
    end

`ifdef ALU_OVF_EN
    always_comb begin
        bus.ovf = 1'b0;
        case (alu_op_e'(bus.ctrl))
            OP_ADD:  bus.ovf = (bus.a[W-1] == bus.b[W-1]) && (w_sum[W-1]  != bus.a[W-1]);
            OP_SUB:  bus.ovf = (bus.a[W-1] != bus.b[W-1]) && (w_diff[W-1] != bus.a[W-1]);
            default: bus.ovf = 1'b0;
        endcase
    end
`endif

    assign bus.out       = w_res;
    assign bus.done      = w_done;
    assign bus.div_state = w_div_state;

endmodule

// File: tb/tb_alu.sv
// Scoreboarded bench for alu: driver pushes expected results, a negedge monitor pops and compares.
// Reference model uses wide integer arithmetic; honours ALU_OVF_EN when defined.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic divrst;
    always #5 clk = ~clk;

    alu_if #(.W(W)) bus();

    alu #(.W(W)) dut (
        .clk    (clk),
        .divrst (divrst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_comp_q[$];
    logic         exp_done_q[$];
    string        tag_q[$];
`ifdef ALU_OVF_EN
    logic         exp_ovf_q[$];
`endif
    logic         tb_vld = 1'b0;
    logic         done_exp = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub, p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = int'(ub % 32);
        p  = longint'(1) << sh;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return W'(ua + ub);
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return W'(ua * p);
            4'd6:  return W'(ua - ub);
            4'd7:  return (sa < sb) ? W'(1) : W'(0);
            4'd8:  return W'(ua / p);
            4'd9:  return (sa >= 0) ? W'(sa / p) : W'(-((-sa + p - 1) / p));
            4'd10: return (ua < ub) ? W'(1) : W'(0);
            4'd11: return W'((ub % 65536) * 65536);
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] ref_comp(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sa == sb) return 2'b00;
        if (sa < sb)  return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd2)      r = sa + sb;
        else if (op == 4'd6) r = sa - sb;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic ref_div(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (op[1] == 1'b0) begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = W'(ua / ub);
            r = W'(ua % ub);
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] corner[5];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return corner[$urandom_range(0, 4)];
            1:       return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eo, input logic ed, input string tag);
        bus.ctrl = op;
        bus.a    = av;
        bus.b    = bv;
        exp_q.push_back(eo);
        exp_comp_q.push_back(ref_comp(av, bv));
        exp_done_q.push_back(ed);
        tag_q.push_back(tag);
`ifdef ALU_OVF_EN
        exp_ovf_q.push_back(ref_ovf(op, av, bv));
`endif
        tb_vld = 1'b1;
        @(posedge clk);
        #1;
        tb_vld = 1'b0;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        issue(op, av, bv, ref_alu(op, av, bv), done_exp, tag);
    endtask

    task automatic div_load(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        bus.a    = av;
        bus.b    = bv;
        bus.ctrl = op;
        divrst   = 1'b0;
        @(posedge clk);
        #1;
        done_exp = 1'b0;
        issue(op, av, bv, '0, 1'b0, {tag, "_in_reset"});
        divrst = 1'b1;
    endtask

    task automatic div_wait(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            if (n == 16) begin
                issue(op, av, bv, '0, 1'b0, {tag, "_busy"});
            end else begin
                bus.ctrl = 4'($urandom_range(0, 15));
                @(posedge clk);
                #1;
            end
            n++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n != W) begin
            errors++;
            $display("FAIL %s_latency: edges=%0d done_seen=%0b required edges=%0d", tag, n, got, W);
        end
        done_exp = 1'b1;
    endtask

    task automatic div_read(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        issue({op[3:1], 1'b0}, av, bv, eq, 1'b1, {tag, "_quo"});
        issue({op[3:1], 1'b1}, av, bv, er, 1'b1, {tag, "_rem"});
        issue({op[3:1], 1'b0}, av, bv, eq, 1'b1, {tag, "_quo_again"});
    endtask

    task automatic div_full(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        div_load(op, av, bv, tag);
        div_wait(op, av, bv, tag);
        div_read(op, av, bv, eq, er, tag);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] m_out;
    logic [1:0]   m_comp;
    logic         m_done;
    string        m_tag;
`ifdef ALU_OVF_EN
    logic         m_ovf;
`endif

    always @(negedge clk) begin
        if (tb_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: output presented with no expected entry");
            end else begin
                m_out  = exp_q.pop_front();
                m_comp = exp_comp_q.pop_front();
                m_done = exp_done_q.pop_front();
                m_tag  = tag_q.pop_front();
                checks++;
                if (bus.out !== m_out) begin
                    errors++;
                    $display("FAIL %s out: got %h expected %h", m_tag, bus.out, m_out);
                end
                checks++;
                if (bus.comp !== m_comp) begin
                    errors++;
                    $display("FAIL %s comp: got %b expected %b", m_tag, bus.comp, m_comp);
                end
                checks++;
                if (bus.done !== m_done) begin
                    errors++;
                    $display("FAIL %s done: got %b expected %b", m_tag, bus.done, m_done);
                end
`ifdef ALU_OVF_EN
                m_ovf = exp_ovf_q.pop_front();
                checks++;
                if (bus.ovf !== m_ovf) begin
                    errors++;
                    $display("FAIL %s ovf: got %b expected %b", m_tag, bus.ovf, m_ovf);
                end
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] av, bv, q, r;
        logic [3:0]   op;

        divrst   = 1'b0;
        bus.a    = '0;
        bus.b    = '0;
        bus.ctrl = 4'b0000;
        @(posedge clk);
        #1;

        // reset state: divider results read as zero, done low
        issue(4'b1100, 32'd5, 32'd2, '0, 1'b0, "reset_divq");
        issue(4'b1111, 32'd5, 32'd2, '0, 1'b0, "reset_divur");

        // directed combinational cases
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, "add_wrap");
        issue(4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, "sub_wrap");
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, "slt_neg");
        issue(4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, "sltu_big");
        issue(4'b1001, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, "sra_4");
        issue(4'b1000, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, "srl_shamt_masked");
        issue(4'b0101, 32'h0000_0003, 32'h1F, 32'h8000_0000, 1'b0, "sll_31");
        issue(4'b1011, 32'h0, 32'hABCD_1234, 32'h1234_0000, 1'b0, "lui");
        issue(4'b0100, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 1'b0, "nor");
        issue(4'b0000, 32'd3, 32'd3, 32'd3, 1'b0, "comp_eq");
        issue(4'b0001, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, "comp_lt");
        issue(4'b0011, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 1'b0, "comp_gt");

        // random combinational ops while divider is held in reset
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 11));
            alu_op(op, rand_opnd(), rand_opnd(), "rand_alu");
        end

        // directed divisions
        div_full(4'b1100, 32'd5, 32'd2, 32'd2, 32'd1, "div_5_2");
        div_full(4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        div_full(4'b1110, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, "divu_m7_2");
        div_full(4'b1100, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, "div_by_zero");
        div_full(4'b1101, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "div_neg_by_zero");
        div_full(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_ovf");

        // abort mid-division, then restart with same operands
        div_load(4'b1100, 32'd100, 32'd7, "abort_a");
        repeat (10) @(posedge clk);
        #1;
        div_full(4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, "abort_same");

        // abort mid-division, reload picks up the new operands
        div_load(4'b1110, 32'd1000, 32'd3, "abort_b");
        repeat (10) @(posedge clk);
        #1;
        div_full(4'b1101, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "abort_reload");

        // done and results hold across unrelated ops
        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 11));
            alu_op(op, rand_opnd(), rand_opnd(), "rand_alu_hold");
        end

        // random divisions against the model
        for (int i = 0; i < 8; i++) begin
            av = rand_opnd();
            bv = (i == 3) ? '0 : rand_opnd();
            op = {2'b11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            ref_div(op, av, bv, q, r);
            div_full(op, av, bv, q, r, "rand_div");
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
